// File: rtl/bip_control.sv
// bip_control: single-cycle control unit for a minimal basic-instruction
// processor. It holds the program counter and the IDLE/RUN/HALT sequencer,
// and decodes the current program word combinationally into datapath
// controls so that exactly one instruction retires per clock in RUN.
module bip_control #(
    parameter int PC_WIDTH     = 11,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         instruction,
    output logic [PC_WIDTH-1:0] pc_addr,
    output logic [PC_WIDTH-1:0] operand,
    output logic [1:0]          SelA,
    output logic                SelB,
    output logic                WrAcc,
    output logic                Op,
    output logic                WrRam,
    output logic                RdRam,
    output logic                halted,
    output logic [15:0]         cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

    localparam logic [1:0] SELA_MEM = 2'd0;
    localparam logic [1:0] SELA_IMM = 2'd1;
    localparam logic [1:0] SELA_ADD = 2'd2;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [PC_WIDTH-1:0]   pc_nxt_s;
    logic [15:0]           cnt_r;
    logic [15:0]           cnt_nxt_s;

    logic [OPCODE_WIDTH-1:0] opcode_s;
    logic [1:0]              sel_a_s;
    logic                    sel_b_s;
    logic                    wr_acc_s;
    logic                    op_s;
    logic                    wr_ram_s;
    logic                    rd_ram_s;

    assign opcode_s = instruction[15 -: OPCODE_WIDTH];

    // State, program counter and RUN-cycle counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {PC_WIDTH{1'b0}};
            cnt_r   <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state sequencing and instruction decode; controls are only live in RUN
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        sel_a_s     = 2'd0;
        sel_b_s     = 1'b0;
        wr_acc_s    = 1'b0;
        op_s        = 1'b0;
        wr_ram_s    = 1'b0;
        rd_ram_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                pc_nxt_s = {PC_WIDTH{1'b0}};
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The edge that consumes HLT still counts as a RUN cycle
                if (cnt_r != 16'hFFFF) begin
                    cnt_nxt_s = cnt_r + 16'd1;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                // Natural wrap of the PC at 2^PC_WIDTH
                pc_nxt_s = pc_r + PC_WIDTH'(1);
                case (opcode_s)
                    OP_HLT: begin
                        pc_nxt_s    = pc_r;
                        state_nxt_s = ST_HALT;
                    end
                    OP_STO: begin
                        wr_ram_s = 1'b1;
                    end
                    OP_LD: begin
                        sel_a_s  = SELA_MEM;
                        wr_acc_s = 1'b1;
                        rd_ram_s = 1'b1;
                    end
                    OP_LDI: begin
                        sel_a_s  = SELA_IMM;
                        wr_acc_s = 1'b1;
                    end
                    OP_ADD: begin
                        sel_a_s  = SELA_ADD;
                        sel_b_s  = 1'b0;
                        wr_acc_s = 1'b1;
                        rd_ram_s = 1'b1;
                    end
                    OP_ADDI: begin
                        sel_a_s  = SELA_ADD;
                        sel_b_s  = 1'b1;
                        wr_acc_s = 1'b1;
                    end
                    OP_SUB: begin
                        sel_a_s  = SELA_ADD;
                        sel_b_s  = 1'b0;
                        op_s     = 1'b1;
                        wr_acc_s = 1'b1;
                        rd_ram_s = 1'b1;
                    end
                    OP_SUBI: begin
                        sel_a_s  = SELA_ADD;
                        sel_b_s  = 1'b1;
                        op_s     = 1'b1;
                        wr_acc_s = 1'b1;
                    end
                    default: begin
                        // Undefined opcodes behave as NOP: no enables, PC advances
                        sel_a_s = 2'd0;
                    end
                endcase
            end
            ST_HALT: begin
                // Terminal until reset: everything frozen
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = {PC_WIDTH{1'b0}};
            end
        endcase
    end

    assign pc_addr     = pc_r;
    assign operand     = instruction[PC_WIDTH-1:0];
    assign SelA        = sel_a_s;
    assign SelB        = sel_b_s;
    assign WrAcc       = wr_acc_s;
    assign Op          = op_s;
    assign WrRam       = wr_ram_s;
    assign RdRam       = rd_ram_s;
    assign halted      = (state_r == ST_HALT);
    assign cycle_count = cnt_r;

endmodule

// File: tb/tb_bip_control.sv
// Directed testbench for bip_control: an asynchronous ROM model feeds the
// DUT and each step compares outputs with hand-computed values.
module tb_bip_control;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] instruction;
    logic [10:0] pc_addr;
    logic [10:0] operand;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic        halted;
    logic [15:0] cycle_count;

    logic [15:0] rom [0:2047];

    int n_checks;
    int n_errors;

    bip_control #(.PC_WIDTH(11), .OPCODE_WIDTH(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .pc_addr     (pc_addr),
        .operand     (operand),
        .SelA        (SelA),
        .SelB        (SelB),
        .WrAcc       (WrAcc),
        .Op          (Op),
        .WrRam       (WrRam),
        .RdRam       (RdRam),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    assign instruction = rom[pc_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle {SelA, SelB, Op, WrAcc, WrRam, RdRam}
    function automatic logic [6:0] ctl(input logic [1:0] sa, input logic sb, input logic op,
                                       input logic wa, input logic wr, input logic rd);
        return {sa, sb, op, wa, wr, rd};
    endfunction

    function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
        return {opc, opd};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) rom[i] = w;
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [6:0] ctl_s;
    assign ctl_s = {SelA, SelB, Op, WrAcc, WrRam, RdRam};

    initial begin
        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        rst_n    = 1'b1;

        // Program 1: LDI 5, ADDI 3, STO 10, HLT
        fill_rom(ins(5'b01000, 11'd0));
        rom[0] = ins(5'b00011, 11'd5);
        rom[1] = ins(5'b00101, 11'd3);
        rom[2] = ins(5'b00001, 11'd10);
        rom[3] = ins(5'b00000, 11'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_pc", 32'(pc_addr), 32'd0);
        check("rst_cnt", 32'(cycle_count), 32'd0);
        check("rst_halt", 32'(halted), 32'd0);
        check("idle_ctl", 32'(ctl_s), 32'(ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_hold_pc", 32'(pc_addr), 32'd0);
        check("idle_hold_ctl", 32'(ctl_s), 32'd0);
        do_start();
        check("p1_ldi", 32'(ctl_s), 32'(ctl(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        tick();
        check("p1_addi", 32'(ctl_s), 32'(ctl(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
        check("p1_pc1", 32'(pc_addr), 32'd1);
        tick();
        check("p1_sto", 32'(ctl_s), 32'(ctl(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
        check("p1_sto_opd", 32'(operand), 32'd10);
        tick();
        check("p1_hlt_ctl", 32'(ctl_s), 32'd0);
        check("p1_hlt_not_yet", 32'(halted), 32'd0);
        tick();
        check("p1_halted", 32'(halted), 32'd1);
        check("p1_pc", 32'(pc_addr), 32'd3);
        check("p1_cnt", 32'(cycle_count), 32'd4);

        // HALT ignores start and a changed instruction
        rom[3] = ins(5'b00011, 11'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("halt_ctl", 32'(ctl_s), 32'd0);
        check("halt_pc", 32'(pc_addr), 32'd3);
        check("halt_cnt", 32'(cycle_count), 32'd4);
        check("halt_stay", 32'(halted), 32'd1);

        // Program 2: LD 7, SUB 8, HLT
        fill_rom(ins(5'b01000, 11'd0));
        rom[0] = ins(5'b00010, 11'd7);
        rom[1] = ins(5'b00110, 11'd8);
        rom[2] = ins(5'b00000, 11'd0);
        do_reset();
        check("p2_rst_halt", 32'(halted), 32'd0);
        do_start();
        check("p2_ld", 32'(ctl_s), 32'(ctl(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)));
        check("p2_ld_opd", 32'(operand), 32'd7);
        tick();
        check("p2_sub", 32'(ctl_s), 32'(ctl(2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1)));
        tick();
        tick();
        check("p2_halted", 32'(halted), 32'd1);
        check("p2_cnt", 32'(cycle_count), 32'd3);
        check("p2_pc", 32'(pc_addr), 32'd2);

        // Program 3: undefined opcode then HLT
        fill_rom(ins(5'b01000, 11'd0));
        rom[0] = ins(5'b11111, 11'h7FF);
        rom[1] = ins(5'b00000, 11'd0);
        do_reset();
        do_start();
        check("p3_nop_ctl", 32'(ctl_s), 32'd0);
        tick();
        check("p3_pc1", 32'(pc_addr), 32'd1);
        check("p3_not_halt", 32'(halted), 32'd0);
        tick();
        check("p3_halted", 32'(halted), 32'd1);
        check("p3_pc", 32'(pc_addr), 32'd1);
        check("p3_cnt", 32'(cycle_count), 32'd2);

        // Asynchronous reset mid-RUN at PC 4, start held high in RUN
        fill_rom(ins(5'b01000, 11'd0));
        rom[4] = ins(5'b00011, 11'd2);
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("ar_pc4", 32'(pc_addr), 32'd4);
        check("ar_ctl_pre", 32'(ctl_s), 32'(ctl(2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pc0", 32'(pc_addr), 32'd0);
        check("ar_cnt0", 32'(cycle_count), 32'd0);
        check("ar_ctl0", 32'(ctl_s), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("ar_idle_pc", 32'(pc_addr), 32'd0);
        check("ar_idle_cnt", 32'(cycle_count), 32'd0);
        do_start();
        tick();
        check("ar_restart_pc", 32'(pc_addr), 32'd1);
        check("ar_restart_cnt", 32'(cycle_count), 32'd1);

        // PC wrap over a ROM full of NOPs
        fill_rom(ins(5'b01000, 11'd0));
        do_reset();
        do_start();
        for (int i = 0; i < 2047; i++) tick();
        check("wr_pc_top", 32'(pc_addr), 32'd2047);
        tick();
        check("wr_pc_zero", 32'(pc_addr), 32'd0);
        tick();
        tick();
        check("wr_pc2", 32'(pc_addr), 32'd2);
        check("wr_cnt", 32'(cycle_count), 32'd2050);
        check("wr_no_halt", 32'(halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bip_control.md
BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 Parameter PC_WIDTH, default 11, program-counter and operand width.
REQ-002 Parameter OPCODE_WIDTH, default 5, opcode field width; instruction = {opcode, operand}, 16 bits total.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; begins execution from IDLE.
REQ-006 instruction  input  16  program-memory word at pc_addr, valid in the same cycle (asynchronous ROM).
REQ-007 pc_addr  output  PC_WIDTH  program-memory address = current PC.
REQ-008 operand  output  11  instruction[10:0], passed straight to the datapath (datapath sign-extends).
REQ-009 SelA  output  2  datapath ACC source: 0 data memory, 1 extended operand, 2 adder result.
REQ-010 SelB  output  1  adder B source: 0 data memory, 1 extended operand.
REQ-011 WrAcc  output  1  ACC write enable.
REQ-012 Op  output  1  0 add, 1 subtract.
REQ-013 WrRam  output  1  data-memory write enable (stores ACC at operand address).
REQ-014 RdRam  output  1  data-memory read enable.
REQ-015 halted  output  1  high while in HALT.
REQ-016 cycle_count  output  16  clocks spent in RUN.

Function
REQ-017 The block SHALL implement FSM states IDLE, RUN, HALT.
REQ-018 IDLE -> RUN on rising edge with start=1; otherwise remain in IDLE; PC held at 0.
REQ-019 In RUN, decode is combinational from instruction; PC increments by 1 on each rising edge except on HLT.
REQ-020 Decode table (opcode: SelA,SelB,Op,WrAcc,WrRam,RdRam): HLT 00000: x,x,0,0,0,0; STO 00001: x,x,0,0,1,0; LD 00010: 0,x,0,1,0,1; LDI 00011: 1,x,0,1,0,0; ADD 00100: 2,0,0,1,0,1; ADDI 00101: 2,1,0,1,0,0; SUB 00110: 2,0,1,1,0,1; SUBI 00111: 2,1,1,1,0,0; don't-care outputs driven 0.
REQ-021 Undefined opcodes (01000-11111) SHALL execute as NOP: all enables 0, PC increments.
REQ-022 HLT in RUN: RUN -> HALT on next edge, PC not incremented (pc_addr stays at the HLT address).
REQ-023 HALT is terminal until reset; start ignored; PC and cycle_count frozen.
REQ-024 In IDLE and HALT, WrAcc, WrRam, RdRam, Op, SelA, SelB SHALL be 0 regardless of instruction.
REQ-025 PC SHALL wrap from 2^PC_WIDTH-1 to 0 without stall or flag.
REQ-026 cycle_count increments on every rising edge in RUN (including the edge that consumes HLT), saturating at 0xFFFF.
REQ-027 start held high in RUN has no effect; start deasserted in RUN does not pause execution.
REQ-028 Exactly one instruction retires per clock in RUN (single-cycle, zero pipeline latency).

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, PC=0, cycle_count=0, halted=0, all enables 0, independent of clk.
REQ-030 Reset mid-RUN or in HALT SHALL abort execution; after rst_n rises, restart requires start=1.
REQ-031 Release of rst_n SHALL be synchronous-safe: first state change occurs no earlier than first rising edge after release.

Verification
REQ-032 Reset, start=1 one cycle, program {LDI 5, ADDI 3, STO 10, HLT} -> cycle 1 WrAcc=1 SelA=1; cycle 2 SelA=2 SelB=1 Op=0; cycle 3 WrRam=1 operand=10; then halted=1, pc_addr=3, cycle_count=4.
REQ-033 Program {LD 7, SUB 8, HLT} -> LD: RdRam=1 SelA=0 WrAcc=1; SUB: SelA=2 SelB=0 Op=1 RdRam=1; halted after 3 RUN cycles.
REQ-034 Opcode 11111 at PC 0 followed by HLT -> all enables 0 for one cycle, PC advances to 1, then HALT with pc_addr=1.
REQ-035 PC preloaded path: ROM of NOPs (01000) for 2048+2 cycles -> pc_addr wraps 2047 -> 0, no halt, cycle_count=2050.
REQ-036 Assert rst_n=0 between clock edges during RUN at PC 4 -> PC=0, IDLE, enables 0 immediately; no progress until start=1.
REQ-037 In HALT, pulse start and toggle instruction to LDI -> no output change, pc_addr and cycle_count frozen.
